// File: rtl/frog_game_pkg.sv
// Shared types and constants for the frog game controller: state codes,
// output widths, button/move ordering and the move priority picker.
package frog_game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PLAY = 3'd1,
    ST_HIT  = 3'd2,
    ST_WIN  = 3'd3,
    ST_OVER = 3'd4
  } state_e;

  localparam int LIVES_W   = 2;
  localparam int SCORE_W   = 8;
  localparam int LIVES_MAX = 3;
  localparam int SCORE_MAX = 255;

  // Button / move vector ordering; lower index wins when several edges coincide.
  localparam int NUM_BTN  = 4;
  localparam int MV_UP    = 0;
  localparam int MV_DOWN  = 1;
  localparam int MV_LEFT  = 2;
  localparam int MV_RIGHT = 3;

  function automatic logic [NUM_BTN-1:0] pick_move(input logic [NUM_BTN-1:0] edges);
    logic [NUM_BTN-1:0] mv;
    mv = '0;
    if      (edges[MV_UP])    mv[MV_UP]    = 1'b1;
    else if (edges[MV_DOWN])  mv[MV_DOWN]  = 1'b1;
    else if (edges[MV_LEFT])  mv[MV_LEFT]  = 1'b1;
    else if (edges[MV_RIGHT]) mv[MV_RIGHT] = 1'b1;
    return mv;
  endfunction

  function automatic logic [LIVES_W-1:0] clamp_lives(input int n);
    if (n > LIVES_MAX) return LIVES_W'(LIVES_MAX);
    if (n < 1)         return LIVES_W'(1);
    return LIVES_W'(n);
  endfunction

endpackage

// File: rtl/sc_edge_detect.sv
// Two-flop button sampler; o_edge is high for one cycle after the button
// is first seen high, so a held button produces a single edge.
module sc_edge_detect (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_edge
);

  logic r_d1, r_d2;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_d1 <= 1'b0;
      r_d2 <= 1'b0;
    end else begin
      r_d1 <= i_btn;
      r_d2 <= r_d1;
    end
  end

  assign o_edge = r_d1 & ~r_d2;

endmodule

// File: rtl/sc_statemachine_frog_game.sv
// Frog game control FSM: move issue with cooldown, collision/HIT handling,
// lives and win/over. Optional score counter under SC_FROG_GAME_SCORE_EN.
module sc_statemachine_frog_game
  import frog_game_pkg::*;
#(
  parameter int LIVES_INIT      = 3,
  parameter int COOLDOWN_CYCLES = 12500000,
  parameter int HIT_CYCLES      = 25000000,
  parameter int CNT_WIDTH       = 26
) (
  input  logic               SC_STATEMACHINE_FROG_GAME_CLOCK_50,
  input  logic               SC_STATEMACHINE_FROG_GAME_RESET,
  input  logic               SC_STATEMACHINE_FROG_GAME_START,
  input  logic               SC_STATEMACHINE_FROG_GAME_BTN_UP,
  input  logic               SC_STATEMACHINE_FROG_GAME_BTN_DOWN,
  input  logic               SC_STATEMACHINE_FROG_GAME_BTN_LEFT,
  input  logic               SC_STATEMACHINE_FROG_GAME_BTN_RIGHT,
  input  logic               SC_STATEMACHINE_FROG_GAME_COLLISION,
  input  logic               SC_STATEMACHINE_FROG_GAME_GOAL,
  output logic               SC_STATEMACHINE_FROG_GAME_MOV_UP,
  output logic               SC_STATEMACHINE_FROG_GAME_MOV_DOWN,
  output logic               SC_STATEMACHINE_FROG_GAME_MOV_LEFT,
  output logic               SC_STATEMACHINE_FROG_GAME_MOV_RIGHT,
  output logic               SC_STATEMACHINE_FROG_GAME_INI,
  output logic [LIVES_W-1:0] SC_STATEMACHINE_FROG_GAME_LIVES,
  output logic [2:0]         SC_STATEMACHINE_FROG_GAME_STATE,
  output logic [SCORE_W-1:0] SC_STATEMACHINE_FROG_GAME_SCORE
);

  localparam logic [CNT_WIDTH-1:0] L_COOL       = CNT_WIDTH'(COOLDOWN_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] L_HIT        = CNT_WIDTH'(HIT_CYCLES - 1);
  localparam logic [LIVES_W-1:0]   L_LIVES_INIT = clamp_lives(LIVES_INIT);

  logic                 w_clk, w_rst;
  logic [NUM_BTN-1:0]   w_btn, w_edge;

  state_e               r_state, w_state_nxt;
  logic [LIVES_W-1:0]   r_lives, w_lives_nxt;
  logic [CNT_WIDTH-1:0] r_cnt,   w_cnt_nxt;
  logic [NUM_BTN-1:0]   r_mov,   w_mov_nxt;
  logic                 r_ini,   w_ini_nxt;

  assign w_clk = SC_STATEMACHINE_FROG_GAME_CLOCK_50;
  assign w_rst = SC_STATEMACHINE_FROG_GAME_RESET;

  assign w_btn[MV_UP]    = SC_STATEMACHINE_FROG_GAME_BTN_UP;
  assign w_btn[MV_DOWN]  = SC_STATEMACHINE_FROG_GAME_BTN_DOWN;
  assign w_btn[MV_LEFT]  = SC_STATEMACHINE_FROG_GAME_BTN_LEFT;
  assign w_btn[MV_RIGHT] = SC_STATEMACHINE_FROG_GAME_BTN_RIGHT;

  sc_edge_detect u_edge [NUM_BTN-1:0] (
    .i_clk  (w_clk),
    .i_rst  (w_rst),
    .i_btn  (w_btn),
    .o_edge (w_edge)
  );

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_state <= ST_IDLE;
      r_lives <= '0;
      r_cnt   <= '0;
      r_mov   <= '0;
      r_ini   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_lives <= w_lives_nxt;
      r_cnt   <= w_cnt_nxt;
      r_mov   <= w_mov_nxt;
      r_ini   <= w_ini_nxt;
    end
  end

  // One counter serves both the move cooldown and the HIT dwell time.
  always_comb begin
    w_state_nxt = r_state;
    w_lives_nxt = r_lives;
    w_cnt_nxt   = (r_cnt != '0) ? r_cnt - CNT_WIDTH'(1) : r_cnt;
    w_mov_nxt   = '0;
    w_ini_nxt   = 1'b0;
    case (r_state)
      ST_IDLE, ST_WIN, ST_OVER: begin
        if (SC_STATEMACHINE_FROG_GAME_START) begin
          w_state_nxt = ST_PLAY;
          w_lives_nxt = L_LIVES_INIT;
          w_ini_nxt   = 1'b1;
          w_cnt_nxt   = '0;
        end
      end
      ST_PLAY: begin
        if (SC_STATEMACHINE_FROG_GAME_COLLISION) begin
          w_state_nxt = ST_HIT;
          w_lives_nxt = (r_lives != '0) ? r_lives - LIVES_W'(1) : r_lives;
          w_ini_nxt   = 1'b1;
          w_cnt_nxt   = L_HIT;
        end else if (SC_STATEMACHINE_FROG_GAME_GOAL) begin
          w_state_nxt = ST_WIN;
        end else if (r_cnt == '0 && |w_edge) begin
          w_mov_nxt = pick_move(w_edge);
          w_cnt_nxt = L_COOL;
        end
      end
      ST_HIT: begin
        if (r_cnt == '0) w_state_nxt = (r_lives != '0) ? ST_PLAY : ST_OVER;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign SC_STATEMACHINE_FROG_GAME_MOV_UP    = r_mov[MV_UP];
  assign SC_STATEMACHINE_FROG_GAME_MOV_DOWN  = r_mov[MV_DOWN];
  assign SC_STATEMACHINE_FROG_GAME_MOV_LEFT  = r_mov[MV_LEFT];
  assign SC_STATEMACHINE_FROG_GAME_MOV_RIGHT = r_mov[MV_RIGHT];
  assign SC_STATEMACHINE_FROG_GAME_INI       = r_ini;
  assign SC_STATEMACHINE_FROG_GAME_LIVES     = r_lives;
  assign SC_STATEMACHINE_FROG_GAME_STATE     = r_state;

`ifdef SC_FROG_GAME_SCORE_EN
  logic               w_win;
  logic [SCORE_W-1:0] r_score;

  assign w_win = (r_state == ST_PLAY) && (w_state_nxt == ST_WIN);

  always_ff @(posedge w_clk) begin
    if (w_rst)                                            r_score <= '0;
    else if (w_win && r_score != SCORE_W'(SCORE_MAX))     r_score <= r_score + SCORE_W'(1);
  end

  assign SC_STATEMACHINE_FROG_GAME_SCORE = r_score;
`else
  assign SC_STATEMACHINE_FROG_GAME_SCORE = '0;
`endif

endmodule

// File: doc/sc_statemachine_frog_game.md
SC_STATEMACHINE_FROG_GAME -- requirements
Module: sc_statemachine_frog_game

Interface
REQ-001 Parameter LIVES_INIT, default 3: lives loaded on game start, range 1..3.
REQ-002 Parameter COOLDOWN_CYCLES, default 12500000: minimum cycles between two issued moves.
REQ-003 Parameter HIT_CYCLES, default 25000000: cycles spent in HIT before resuming.
REQ-004 Parameter CNT_WIDTH, default 26: width of the shared cooldown/hit counter.
REQ-005 SC_STATEMACHINE_FROG_GAME_CLOCK_50  in  1  single clock, all logic on rising edge.
REQ-006 SC_STATEMACHINE_FROG_GAME_RESET  in  1  reset, synchronous, active-high.
REQ-007 SC_STATEMACHINE_FROG_GAME_START  in  1  level, start/restart request.
REQ-008 SC_STATEMACHINE_FROG_GAME_BTN_UP/_DOWN/_LEFT/_RIGHT  in  1 each  raw level buttons, active-high.
REQ-009 SC_STATEMACHINE_FROG_GAME_COLLISION  in  1  frog cell overlaps an obstacle (frog matrix AND obstacle matrix nonzero).
REQ-010 SC_STATEMACHINE_FROG_GAME_GOAL  in  1  frog is in the top row.
REQ-011 SC_STATEMACHINE_FROG_GAME_MOV_UP/_DOWN/_LEFT/_RIGHT  out  1 each  one-cycle move pulses to the frog position machines.
REQ-012 SC_STATEMACHINE_FROG_GAME_INI  out  1  one-cycle pulse returning the frog to its start cell.
REQ-013 SC_STATEMACHINE_FROG_GAME_LIVES  out  2  remaining lives.
REQ-014 SC_STATEMACHINE_FROG_GAME_STATE  out  3  current state code.
REQ-015 SC_STATEMACHINE_FROG_GAME_SCORE  out  8  goals reached (see Configuration).

Function
REQ-016 States: IDLE=0, PLAY=1, HIT=2, WIN=3, OVER=4; codes 5..7 unreachable, recover to IDLE next cycle.
REQ-017 IDLE/WIN/OVER + START=1 -> PLAY; same edge: LIVES<=LIVES_INIT, INI pulse, counter cleared.
REQ-018 Buttons registered once (d1), then again (d2); press edge = d1 & ~d2; a held button yields exactly one edge.
REQ-019 In PLAY with counter==0 and at least one edge: issue one MOV pulse, priority UP > DOWN > LEFT > RIGHT, counter<=COOLDOWN_CYCLES-1; other simultaneous edges discarded.
REQ-020 MOV pulse high the cycle after the edge is detected: 2-clock latency from button sampled high; never two MOV outputs high together.
REQ-021 Counter nonzero: decrement by 1 per cycle, saturate at 0; edges arriving meanwhile discarded, not queued.
REQ-022 PLAY + COLLISION=1 -> HIT: LIVES decrements by 1, INI pulse, counter<=HIT_CYCLES-1, no MOV that cycle.
REQ-023 HIT with counter==0: LIVES>0 -> PLAY, LIVES==0 -> OVER; COLLISION and buttons ignored in HIT.
REQ-024 PLAY + GOAL=1 + COLLISION=0 -> WIN; COLLISION and GOAL together -> HIT (collision wins).
REQ-025 MOV and INI outputs are 0 in IDLE, WIN, OVER except INI per REQ-017.
REQ-026 LIVES never wraps below 0 nor exceeds 3.

Reset
REQ-027 RESET=1 at any edge, including mid-HIT or mid-cooldown: state IDLE, LIVES 0, counter 0, d1/d2 0, SCORE 0, all pulses 0.
REQ-028 RESET has priority over START and all other inputs in the same cycle.

Configuration
REQ-029 Macro SC_FROG_GAME_SCORE_EN defined: SCORE increments by 1 on each PLAY->WIN transition, saturates at 255, cleared only by RESET.
REQ-030 Macro undefined: SCORE port present, tied to 0, no score register synthesized.

Structure
REQ-031 Package frog_game_pkg holds state enum/codes, LIVES/SCORE widths, move-priority constants.
REQ-032 One sub-module sc_edge_detect (d1/d2 register pair + edge output), instantiated once per button.

Verification
REQ-033 Reset, START pulse -> next cycle STATE=1, LIVES=3, INI=1 for exactly one cycle.
REQ-034 COOLDOWN_CYCLES=4, UP held 20 cycles -> exactly one MOV_UP pulse, 2 cycles after UP sampled high.
REQ-035 UP and LEFT rise same cycle -> only MOV_UP; LEFT re-pressed 2 cycles later (cooldown active) -> no MOV_LEFT.
REQ-036 HIT_CYCLES=5, three collisions in PLAY -> LIVES 2,1,0, three INI pulses, final STATE=4 after 5 HIT cycles.
REQ-037 COLLISION and GOAL same cycle -> STATE=2, LIVES decremented, SCORE unchanged; GOAL alone with SC_FROG_GAME_SCORE_EN -> STATE=3, SCORE+1.
REQ-038 RESET asserted during HIT -> next cycle STATE=0, LIVES=0, no INI pulse.
